// File: rtl/scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// scan_ctrl_pkg
// Shared definitions for the scan chain sequencer:
//   - scan_state_e : sequencer states (IDLE, SHIFT, CAPTURE, FLUSH_SH)
//   - shift_cnt_w(): width of the per-shift bit counter, max(1, clog2(n))
// -----------------------------------------------------------------------------
package scan_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    CAPTURE  = 2'd2,
    FLUSH_SH = 2'd3
  } scan_state_e;

  // A chain of one or two cells still needs a one-bit counter.
  function automatic int shift_cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scan_shreg.sv
// -----------------------------------------------------------------------------
// scan_shreg
// Parallel-load, serial-in shift register. Shifts toward bit 0, with the
// serial input entering at the MSB, so after WIDTH shifts bit k holds the
// k-th bit that was shifted in, and bit 0 always presents the next bit out.
// Ports:
//   CLK, RSTB  : clock, asynchronous active-low reset (clears to 0)
//   load       : load load_data (has priority over shift)
//   load_data  : parallel load value
//   shift      : shift one position toward bit 0
//   ser_in     : bit entering at the MSB on a shift
//   q          : register contents
// -----------------------------------------------------------------------------
module scan_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RSTB,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] q_next;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      if (gi == WIDTH - 1) begin : g_head
        assign shifted[gi] = ser_in;
      end else begin : g_body
        assign shifted[gi] = q_reg[gi+1];
      end
    end
  endgenerate

  always_comb begin
    q_next = q_reg;
    if (load) begin
      q_next = load_data;
    end else if (shift) begin
      q_next = shifted;
    end
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      q_reg <= '0;
    end else begin
      q_reg <= q_next;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/scan_chain_ctrl.sv
// -----------------------------------------------------------------------------
// scan_chain_ctrl
// Sequences one scan chain of CHAIN_LEN scan flops through load/capture/unload
// cycles. Stimulus patterns arrive on a valid/ready handshake, responses
// leave on another; the chain is driven through SE, SI and its clock-gate
// enable, and the chain tail is sampled on SO.
// Ports:
//   CLK, RSTB             : clock, asynchronous active-low reset
//   PAT_VALID/READY/IN    : stimulus handshake, PAT_IN[k] is shifted in k-th
//   FLUSH                 : unload the pending response without a new pattern
//   RSP_VALID/READY/OUT   : response handshake, RSP_OUT[k] was shifted out k-th
//   SCAN_SE, SCAN_SI      : chain scan enable and head serial input (registered)
//   SCAN_CLK_EN           : chain clock-gate enable (registered)
//   SCAN_SO               : chain tail output
//   BUSY                  : sequencer not idle
//   PAT_CNT               : completed capture cycles, wrapping
// -----------------------------------------------------------------------------
module scan_chain_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN = 8,
  parameter int CNT_W     = 16
) (
  input  logic                 CLK,
  input  logic                 RSTB,
  input  logic                 PAT_VALID,
  output logic                 PAT_READY,
  input  logic [CHAIN_LEN-1:0] PAT_IN,
  input  logic                 FLUSH,
  output logic                 RSP_VALID,
  input  logic                 RSP_READY,
  output logic [CHAIN_LEN-1:0] RSP_OUT,
  output logic                 SCAN_SE,
  output logic                 SCAN_SI,
  output logic                 SCAN_CLK_EN,
  input  logic                 SCAN_SO,
  output logic                 BUSY,
  output logic [CNT_W-1:0]     PAT_CNT
);

  localparam int SCW = shift_cnt_w(CHAIN_LEN);
  localparam logic [SCW-1:0] LAST = SCW'(CHAIN_LEN - 1);

  scan_state_e      state_reg, state_next;
  logic [SCW-1:0]   cnt_reg, cnt_next;
  logic             pending_reg, pending_next;
  logic             rsp_valid_reg, rsp_valid_next;
  logic [CNT_W-1:0] pat_cnt_reg, pat_cnt_next;
  logic             se_reg, se_next;
  logic             clk_en_reg, clk_en_next;

  logic             accept;
  logic             start_flush;
  logic             shifting;
  logic             last_shift;
  logic [CHAIN_LEN-1:0] stim_q;

  // No new pattern while a response is still waiting: the unload of the next
  // shift would overwrite it, so we stall in IDLE with the chain clock gated.
  assign PAT_READY   = (state_reg == IDLE) && !rsp_valid_reg;
  assign accept      = PAT_VALID && PAT_READY;
  assign start_flush = (state_reg == IDLE) && !accept && FLUSH &&
                       pending_reg && !rsp_valid_reg;
  assign shifting    = (state_reg == SHIFT) || (state_reg == FLUSH_SH);
  assign last_shift  = shifting && (cnt_reg == LAST);

  always_comb begin
    state_next     = state_reg;
    cnt_next       = '0;
    pending_next   = pending_reg;
    rsp_valid_next = rsp_valid_reg;
    pat_cnt_next   = pat_cnt_reg;

    if (rsp_valid_reg && RSP_READY) begin
      rsp_valid_next = 1'b0;
    end
    if (shifting && !last_shift) begin
      cnt_next = cnt_reg + SCW'(1);
    end

    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = SHIFT;
        end else if (start_flush) begin
          state_next = FLUSH_SH;
        end
      end
      SHIFT: begin
        if (last_shift) begin
          state_next = CAPTURE;
          // Unload data is only meaningful if a capture preceded this shift.
          if (pending_reg) begin
            rsp_valid_next = 1'b1;
          end
        end
      end
      CAPTURE: begin
        state_next   = IDLE;
        pending_next = 1'b1;
        pat_cnt_next = pat_cnt_reg + CNT_W'(1);
      end
      FLUSH_SH: begin
        if (last_shift) begin
          state_next     = IDLE;
          rsp_valid_next = 1'b1;
          pending_next   = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Chain controls are registered from the next state so they switch on the
  // same edge as the state and the shift counter.
  always_comb begin
    se_next     = (state_next == SHIFT) || (state_next == FLUSH_SH);
    clk_en_next = (state_next != IDLE);
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      pending_reg   <= 1'b0;
      rsp_valid_reg <= 1'b0;
      pat_cnt_reg   <= '0;
      se_reg        <= 1'b0;
      clk_en_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      pending_reg   <= pending_next;
      rsp_valid_reg <= rsp_valid_next;
      pat_cnt_reg   <= pat_cnt_next;
      se_reg        <= se_next;
      clk_en_reg    <= clk_en_next;
    end
  end

  // Stimulus: loaded on accept, shifted once per SHIFT cycle with zero fill.
  // Its bit 0 is the registered SI, so it shows PAT_IN[k] in SHIFT cycle k.
  scan_shreg #(.WIDTH(CHAIN_LEN)) u_stim (
    .CLK       (CLK),
    .RSTB      (RSTB),
    .load      (accept),
    .load_data (PAT_IN),
    .shift     (state_reg == SHIFT),
    .ser_in    (1'b0),
    .q         (stim_q)
  );

  // Response: the tail is sampled on each closing shift edge, before the
  // chain moves; the word is held while RSP_VALID because no shift can start.
  scan_shreg #(.WIDTH(CHAIN_LEN)) u_rsp (
    .CLK       (CLK),
    .RSTB      (RSTB),
    .load      (1'b0),
    .load_data ({CHAIN_LEN{1'b0}}),
    .shift     (shifting),
    .ser_in    (SCAN_SO),
    .q         (RSP_OUT)
  );

  // After CHAIN_LEN zero-fill shifts the stimulus register is empty, which is
  // what keeps SI low in IDLE, CAPTURE and FLUSH_SH.
  always_ff @(posedge CLK) begin
    if (RSTB && (state_reg != SHIFT)) begin
      assert (stim_q == '0);
    end
  end

  assign RSP_VALID   = rsp_valid_reg;
  assign SCAN_SE     = se_reg;
  assign SCAN_SI     = stim_q[0];
  assign SCAN_CLK_EN = clk_en_reg;
  assign BUSY        = (state_reg != IDLE);
  assign PAT_CNT     = pat_cnt_reg;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// -----------------------------------------------------------------------------
// tb_scan_chain_ctrl
// Drives scan_chain_ctrl with a 4-cell scan chain model on the gated clock.
// Captured cell values come from d_tie (C0..C3 = 0,1,1,0 in the directed part,
// randomized between patterns later). Expected values come from the chain's
// behavioural rules: a pattern p leaves cell C(N-1-k) = p[k], and an unload
// returns word bit k = cell C(N-1-k) of the last capture.
// -----------------------------------------------------------------------------
module tb_scan_chain_ctrl;

  localparam int N  = 4;
  localparam int CW = 3;

  logic          CLK = 1'b0;
  logic          RSTB;
  logic          PAT_VALID;
  logic          PAT_READY;
  logic [N-1:0]  PAT_IN;
  logic          FLUSH;
  logic          RSP_VALID;
  logic          RSP_READY;
  logic [N-1:0]  RSP_OUT;
  logic          SCAN_SE;
  logic          SCAN_SI;
  logic          SCAN_CLK_EN;
  logic          SCAN_SO;
  logic          BUSY;
  logic [CW-1:0] PAT_CNT;

  scan_chain_ctrl #(.CHAIN_LEN(N), .CNT_W(CW)) dut (
    .CLK         (CLK),
    .RSTB        (RSTB),
    .PAT_VALID   (PAT_VALID),
    .PAT_READY   (PAT_READY),
    .PAT_IN      (PAT_IN),
    .FLUSH       (FLUSH),
    .RSP_VALID   (RSP_VALID),
    .RSP_READY   (RSP_READY),
    .RSP_OUT     (RSP_OUT),
    .SCAN_SE     (SCAN_SE),
    .SCAN_SI     (SCAN_SI),
    .SCAN_CLK_EN (SCAN_CLK_EN),
    .SCAN_SO     (SCAN_SO),
    .BUSY        (BUSY),
    .PAT_CNT     (PAT_CNT)
  );

  always #5 CLK = ~CLK;

  // Scan chain of SDFFX1 cells on the gated clock; chain[i] is cell Ci.
  logic [N-1:0] chain = '0;
  logic [N-1:0] d_tie = 4'b0110;
  assign SCAN_SO = chain[N-1];
  always @(posedge CLK) begin
    if (SCAN_CLK_EN) begin
      chain <= SCAN_SE ? {chain[N-2:0], SCAN_SI} : d_tie;
    end
  end

  int checks = 0;
  int errors = 0;

  // Reference state
  bit           m_pending;
  bit           m_valid;
  int           m_cnt;
  logic [N-1:0] m_cells;   // cell contents left by the last capture
  logic [N-1:0] m_rsp;     // response word currently expected

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bit k of the result is bit N-1-k of the argument: maps a shifted word to
  // cell contents and cell contents to an unloaded word.
  function automatic logic [N-1:0] reversed(input logic [N-1:0] v);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = v[N-1-i];
    return r;
  endfunction

  // Called at a negedge in IDLE with no response outstanding.
  task automatic send_pattern(input logic [N-1:0] p, input bit with_flush);
    PAT_IN    = p;
    PAT_VALID = 1'b1;
    FLUSH     = with_flush;
    chk("pat_ready_idle", 32'(PAT_READY), 1);
    @(negedge CLK);
    PAT_VALID = 1'b0;
    FLUSH     = 1'b0;
    PAT_IN    = 4'($urandom);
    for (int k = 0; k < N; k++) begin
      chk("shift_se", 32'(SCAN_SE), 1);
      chk("shift_clk_en", 32'(SCAN_CLK_EN), 1);
      chk("shift_si", 32'(SCAN_SI), 32'(p[k]));
      chk("shift_busy", 32'(BUSY), 1);
      chk("shift_rsp_valid", 32'(RSP_VALID), 0);
      @(negedge CLK);
    end
    chk("capture_se", 32'(SCAN_SE), 0);
    chk("capture_clk_en", 32'(SCAN_CLK_EN), 1);
    chk("chain_loaded", 32'(chain), 32'(reversed(p)));
    chk("capture_rsp_valid", 32'(RSP_VALID), 32'(m_pending));
    if (m_pending) begin
      m_rsp   = reversed(m_cells);
      m_valid = 1'b1;
      chk("capture_rsp_out", 32'(RSP_OUT), 32'(m_rsp));
    end
    @(negedge CLK);
    m_cells   = d_tie;
    m_pending = 1'b1;
    m_cnt     = (m_cnt + 1) % (1 << CW);
    chk("idle_busy", 32'(BUSY), 0);
    chk("idle_clk_en", 32'(SCAN_CLK_EN), 0);
    chk("idle_se", 32'(SCAN_SE), 0);
    chk("idle_si", 32'(SCAN_SI), 0);
    chk("chain_captured", 32'(chain), 32'(m_cells));
    chk("pat_cnt", 32'(PAT_CNT), m_cnt);
    chk("idle_rsp_valid", 32'(RSP_VALID), 32'(m_valid));
    chk("idle_pat_ready", 32'(PAT_READY), 32'(!m_valid));
    $display("pattern 0x%h flush_req=%0d pat_cnt=%0d rsp_valid=%0d rsp=0x%h",
             p, with_flush, PAT_CNT, RSP_VALID, RSP_OUT);
  endtask

  // Holds RSP_READY low for 'hold' cycles (optionally with a pattern offered),
  // then pulses it once.
  task automatic drain(input int hold, input bit with_pat);
    chk("drain_valid", 32'(RSP_VALID), 1);
    RSP_READY = 1'b0;
    PAT_VALID = with_pat;
    PAT_IN    = 4'($urandom);
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      chk("stall_pat_ready", 32'(PAT_READY), 0);
      chk("stall_clk_en", 32'(SCAN_CLK_EN), 0);
      chk("stall_busy", 32'(BUSY), 0);
      chk("stall_rsp_valid", 32'(RSP_VALID), 1);
      chk("stall_rsp_out", 32'(RSP_OUT), 32'(m_rsp));
    end
    RSP_READY = 1'b1;
    @(negedge CLK);
    RSP_READY = 1'b0;
    PAT_VALID = 1'b0;
    m_valid   = 1'b0;
    chk("drained_valid", 32'(RSP_VALID), 0);
    chk("drained_pat_ready", 32'(PAT_READY), 1);
    chk("drained_clk_en", 32'(SCAN_CLK_EN), 0);
    $display("response 0x%h consumed after %0d stall cycles (pattern offered=%0d)",
             m_rsp, hold, with_pat);
  endtask

  // Called at a negedge in IDLE with no response outstanding.
  task automatic do_flush();
    FLUSH = 1'b1;
    @(negedge CLK);
    FLUSH = 1'b0;
    if (m_pending) begin
      for (int k = 0; k < N; k++) begin
        chk("flush_se", 32'(SCAN_SE), 1);
        chk("flush_clk_en", 32'(SCAN_CLK_EN), 1);
        chk("flush_si", 32'(SCAN_SI), 0);
        chk("flush_busy", 32'(BUSY), 1);
        @(negedge CLK);
      end
      m_rsp     = reversed(m_cells);
      m_pending = 1'b0;
      m_valid   = 1'b1;
      chk("flush_end_busy", 32'(BUSY), 0);
      chk("flush_no_capture", 32'(SCAN_CLK_EN), 0);
      chk("flush_rsp_valid", 32'(RSP_VALID), 1);
      chk("flush_rsp_out", 32'(RSP_OUT), 32'(m_rsp));
      chk("flush_chain_zero", 32'(chain), 0);
      chk("flush_pat_cnt", 32'(PAT_CNT), m_cnt);
      $display("flush: rsp=0x%h pat_cnt=%0d", RSP_OUT, PAT_CNT);
    end else begin
      chk("flush_ignored_busy", 32'(BUSY), 0);
      chk("flush_ignored_clk_en", 32'(SCAN_CLK_EN), 0);
      chk("flush_ignored_rsp_valid", 32'(RSP_VALID), 0);
      $display("flush with nothing pending ignored");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RSTB      = 1'b0;
    PAT_VALID = 1'b0;
    PAT_IN    = '0;
    FLUSH     = 1'b0;
    RSP_READY = 1'b0;
    m_pending = 1'b0;
    m_valid   = 1'b0;
    m_cnt     = 0;
    m_cells   = '0;
    m_rsp     = '0;

    // Reset held, then released
    repeat (3) @(negedge CLK);
    chk("rst_se", 32'(SCAN_SE), 0);
    chk("rst_si", 32'(SCAN_SI), 0);
    chk("rst_clk_en", 32'(SCAN_CLK_EN), 0);
    chk("rst_rsp_valid", 32'(RSP_VALID), 0);
    chk("rst_rsp_out", 32'(RSP_OUT), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_pat_cnt", 32'(PAT_CNT), 0);
    RSTB = 1'b1;
    @(negedge CLK);
    chk("rst_pat_ready", 32'(PAT_READY), 1);
    $display("reset released");

    // First pattern: no response
    d_tie = 4'b0110;
    send_pattern(4'b1011, 1'b0);
    chk("first_pat_cnt", 32'(PAT_CNT), 1);

    // Second pattern: unloads the first capture
    send_pattern(4'b0000, 1'b0);
    chk("second_rsp_out", 32'(RSP_OUT), 32'(4'b0110));
    chk("second_pat_cnt", 32'(PAT_CNT), 2);

    // Back-pressure with a pattern offered, then the shift starts
    drain(3, 1'b1);
    send_pattern(4'b0110, 1'b0);
    drain(2, 1'b0);

    // Flush with pending, then a second flush is ignored
    do_flush();
    chk("flush_word", 32'(RSP_OUT), 32'(4'b0110));
    drain(1, 1'b0);
    do_flush();

    // Pattern and flush requested together: the pattern wins
    send_pattern(4'b1100, 1'b1);

    // Randomized traffic with varying capture data
    for (int it = 0; it < 40; it++) begin
      if (m_valid) drain(int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
      d_tie = 4'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        do_flush();
      end else begin
        send_pattern(4'($urandom), $urandom_range(0, 3) == 0);
      end
    end
    if (m_valid) drain(0, 1'b0);

    // Reset in shift cycle 2
    PAT_IN    = 4'b1001;
    PAT_VALID = 1'b1;
    chk("mid_pat_ready", 32'(PAT_READY), 1);
    @(negedge CLK);
    PAT_VALID = 1'b0;
    repeat (2) @(negedge CLK);
    chk("mid_se_before", 32'(SCAN_SE), 1);
    RSTB = 1'b0;
    #1;
    chk("mid_rst_se", 32'(SCAN_SE), 0);
    chk("mid_rst_clk_en", 32'(SCAN_CLK_EN), 0);
    chk("mid_rst_busy", 32'(BUSY), 0);
    chk("mid_rst_pat_cnt", 32'(PAT_CNT), 0);
    chk("mid_rst_rsp_valid", 32'(RSP_VALID), 0);
    @(negedge CLK);
    RSTB      = 1'b1;
    m_pending = 1'b0;
    m_valid   = 1'b0;
    m_cnt     = 0;
    $display("reset asserted during shift");
    @(negedge CLK);
    chk("mid_rel_pat_ready", 32'(PAT_READY), 1);
    d_tie = 4'b0011;
    send_pattern(4'b0101, 1'b0);
    send_pattern(4'b1110, 1'b0);
    drain(1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_chain_ctrl.md
# scan_chain_ctrl

Sequencer that drives one scan chain of `CHAIN_LEN` SDFFX1 scan flip-flops through load/capture/unload test cycles. It accepts stimulus patterns and returns captured responses over valid/ready handshakes. It drives the chain's shared SE and SI pins and the enable of the chain's clock gate, and samples the chain tail. It sits between the on-chip test pattern source/compactor and the scan-inserted logic.

## Interface
- `CHAIN_LEN`, 8: scan flops in the chain, ≥1.
- `CNT_W`, 16: width of the capture counter.

- `CLK` in 1: clock. Chain flops run on the gated version of it.
- `RSTB` in 1: asynchronous, active-low reset.
- `PAT_VALID` in 1: stimulus pattern offered.
- `PAT_READY` out 1: pattern accepted when `PAT_VALID & PAT_READY`.
- `PAT_IN` in `CHAIN_LEN`: stimulus; bit k is the k-th bit shifted in.
- `FLUSH` in 1: request unload of the pending response without a new pattern.
- `RSP_VALID` out 1: response available.
- `RSP_READY` in 1: response consumed when `RSP_VALID & RSP_READY`.
- `RSP_OUT` out `CHAIN_LEN`: response; bit k is the k-th bit shifted out.
- `SCAN_SE` out 1: scan enable to all chain SE pins. Registered.
- `SCAN_SI` out 1: to the head cell's SI. Registered.
- `SCAN_CLK_EN` out 1: clock-gate enable for the chain. Registered.
- `SCAN_SO` in 1: Q of the chain tail cell.
- `BUSY` out 1: high whenever state ≠ IDLE.
- `PAT_CNT` out `CNT_W`: number of completed capture cycles, wraps.

## Operation
- Chain cells are C0 (head) to C(N-1) (tail), with N = `CHAIN_LEN`. The chain clocks only on edges ending a cycle in which `SCAN_CLK_EN`=1.
- States:
  - IDLE: SE=0, CLK_EN=0, SI=0.
  - SHIFT: N cycles, SE=1, CLK_EN=1.
  - CAPTURE: 1 cycle, SE=0, CLK_EN=1.
  - FLUSH_SH: N cycles, SE=1, CLK_EN=1, SI=0.
- `PAT_READY` = (state==IDLE) & !`RSP_VALID`. Because of this, no response can be lost, and stalls happen only with the chain clock gated.
- Transitions out of IDLE:
  - On accept, load the pattern shift register and go to SHIFT.
  - Otherwise, if `FLUSH` & pending & !`RSP_VALID`, go to FLUSH_SH. `PAT_VALID` wins over `FLUSH`.
  - `FLUSH` with pending=0 is ignored.
- SHIFT, cycle k (k=0..N-1):
  - `SCAN_SI`=`PAT_IN[k]`.
  - At the closing edge, sample `SCAN_SO` into response bit k.
  - After N cycles, cell C(N-1-k) holds `PAT_IN[k]`, and `RSP_OUT[k]` holds the previously captured value of C(N-1-k).
- SHIFT → CAPTURE. On entering CAPTURE, if pending was set, raise `RSP_VALID` with the unloaded word.
- CAPTURE → IDLE. Set pending=1 and increment `PAT_CNT`, wrapping from 2^CNT_W−1 to 0.
- FLUSH_SH: sample exactly as in SHIFT. Go to IDLE, raise `RSP_VALID`, clear pending, leave `PAT_CNT` unchanged. There is no capture cycle.
- The first pattern after reset or after a flush produces no response, because its unload data is discarded.
- `RSP_VALID` stays high until `RSP_READY`. `RSP_OUT` is stable while valid.

## Timing
- Reset (async, any state) → IDLE. Reset values:
  - `SCAN_SE`=0, `SCAN_CLK_EN`=0, `SCAN_SI`=0.
  - `RSP_VALID`=0, `RSP_OUT`=0, `BUSY`=0, `PAT_CNT`=0.
  - pending=0. `PAT_READY`=1 after release.
- Reset mid-shift leaves chain contents undefined. The bench must not check them until a new pattern is loaded.
- Accept edge → SHIFT registered outputs appear the next cycle. Pattern period is N+2 cycles (N SHIFT, 1 CAPTURE, ≥1 IDLE).
- `RSP_VALID` rises in the first CAPTURE cycle, or the first IDLE cycle after FLUSH_SH.
- Shift counter width is max(1, $clog2(N)). N=1 gives a single SHIFT cycle.
- Shift counter, SE, SI and CLK_EN all change on the same edge. SO is sampled on the edge before the chain updates.

## Structure
- Package `scan_ctrl_pkg`: state enum (IDLE, SHIFT, CAPTURE, FLUSH_SH) and the shift-counter width function.
- Sub-module `scan_shreg`: a parallel-load, serial-in/out shift register of `CHAIN_LEN` bits. It is instantiated twice: once for the stimulus (serial out) and once for the response (serial in).

## Test plan
N=4. The bench models 4 SDFFX1 cells on a gated CLK, with the D inputs of C0..C3 tied to 0,1,1,0.
1. Reset held, then released → all outputs 0, `PAT_READY`=1.
2. First pattern `4'b1011` → `SCAN_SI` = 1,1,0,1 over 4 SE=1 cycles, then 1 cycle with SE=0/CLK_EN=1. `RSP_VALID` stays 0 and `PAT_CNT`=1.
3. Second pattern `4'b0000` → `RSP_VALID`=1 in its CAPTURE cycle with `RSP_OUT`=`4'b0110`, and `PAT_CNT`=2.
4. `RSP_READY`=0 held with `PAT_VALID`=1 → `PAT_READY`=0 and `SCAN_CLK_EN`=0 until `RSP_READY` pulses, then the shift starts.
5. `FLUSH` in IDLE with pending → 4 cycles SI=0/SE=1 and no capture cycle. `RSP_OUT`=`4'b0110`, `PAT_CNT` unchanged, and a second `FLUSH` is ignored.
6. `RSTB` low at shift cycle 2 → SE, CLK_EN and BUSY drop immediately, and `PAT_CNT`=0 after reset.
